// File: rtl/txt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : txt_pkg
// Description : Shared definitions for the text write controller: screen
//               geometry defaults, ASCII control codes, controller state enum
//               and cursor operation codes.
// Revision    : 1.0 - initial release
// ============================================================================
package txt_pkg;

  localparam int TXT_COLS = 32;
  localparam int TXT_ROWS = 4;

  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_FF    = 8'h0C;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_BLANK = 8'h20;
  localparam logic [7:0] PRINT_LO    = 8'h20;
  localparam logic [7:0] PRINT_HI    = 8'h7E;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROWCLR = 2'd1,
    SCRCLR = 2'd2
  } txt_state_e;

  typedef enum logic [2:0] {
    CUR_NOP  = 3'd0,
    CUR_HOME = 3'd1,
    CUR_ADV  = 3'd2,
    CUR_NL   = 3'd3,
    CUR_CR   = 3'd4,
    CUR_BACK = 3'd5
  } cur_op_e;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= PRINT_LO) && (b <= PRINT_HI);
  endfunction

endpackage
`default_nettype wire

// File: rtl/text_write_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : text_write_ctrl_if
// Description : Bundle between the UART receive stream, the text RAM write
//               port and the write controller.
//   master : controller side (consumes rx_*/clr_req, drives RAM port/status)
//   slave  : environment side (UART receiver, RAM, cursor display)
//   rx_data/rx_valid/clr_req, busy/rx_drop, ram_we/ram_row/ram_col/ram_wdata,
//   cur_row/cur_col
// Revision    : 1.0 - initial release
// ============================================================================
interface text_write_ctrl_if #(
  parameter int COLS = txt_pkg::TXT_COLS,
  parameter int ROWS = txt_pkg::TXT_ROWS
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);

  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          clr_req;
  logic          busy;
  logic          rx_drop;
  logic          ram_we;
  logic [RW-1:0] ram_row;
  logic [CW-1:0] ram_col;
  logic [7:0]    ram_wdata;
  logic [RW-1:0] cur_row;
  logic [CW-1:0] cur_col;

  modport master (
    input  rx_data, rx_valid, clr_req,
    output busy, rx_drop, ram_we, ram_row, ram_col, ram_wdata, cur_row, cur_col
  );

  modport slave (
    output rx_data, rx_valid, clr_req,
    input  busy, rx_drop, ram_we, ram_row, ram_col, ram_wdata, cur_row, cur_col
  );

endinterface
`default_nettype wire

// File: rtl/text_cursor.sv
`default_nettype none
// ============================================================================
// Module      : text_cursor
// Description : Cursor row/column register with home, advance-with-wrap,
//               newline, carriage-return and back operations.
//   clk, reset (async, active-low), op : operation applied at the next edge
//   row/col  : registered cursor position
//   row_next : row+1 modulo ROWS (target of newline / wrap)
//   wrap     : the requested advance crosses into the next row
// Revision    : 1.0 - initial release
// ============================================================================
module text_cursor
  import txt_pkg::*;
#(
  parameter int COLS = TXT_COLS,
  parameter int ROWS = TXT_ROWS,
  localparam int CW = $clog2(COLS),
  localparam int RW = $clog2(ROWS)
) (
  input  wire logic          clk,
  input  wire logic          reset,
  input  wire cur_op_e       op,
  output logic [RW-1:0]      row,
  output logic [CW-1:0]      col,
  output logic [RW-1:0]      row_next,
  output logic               wrap
);

  localparam logic [CW-1:0] C_COL_MAX = CW'(COLS - 1);

  logic [RW-1:0] r_row, w_row_nxt;
  logic [CW-1:0] r_col, w_col_nxt;
  logic          w_last_col;

  // Row and column wrap through natural width overflow.
  assign row_next   = r_row + 1'b1;
  assign w_last_col = (r_col == C_COL_MAX);
  assign wrap       = (op == CUR_ADV) && w_last_col;
  assign row        = r_row;
  assign col        = r_col;

  always_comb begin
    w_row_nxt = r_row;
    w_col_nxt = r_col;
    case (op)
      CUR_HOME: begin
        w_row_nxt = '0;
        w_col_nxt = '0;
      end
      CUR_ADV: begin
        w_col_nxt = r_col + 1'b1;
        if (w_last_col) w_row_nxt = row_next;
      end
      CUR_NL:   w_row_nxt = row_next;
      CUR_CR:   w_col_nxt = '0;
      // No reverse wrap into the previous row.
      CUR_BACK: if (r_col != '0) w_col_nxt = r_col - 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_row <= '0;
      r_col <= '0;
    end else begin
      r_row <= w_row_nxt;
      r_col <= w_col_nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/text_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : text_write_ctrl
// Description : Turns the UART byte stream into writes on the text RAM write
//               port. Printables are written at the cursor; CR/LF/FF are
//               interpreted; row and screen clears run one cell per cycle.
//               Optional macro TXT_BACKSPACE_EN enables BS handling (step
//               back and blank the cell); otherwise BS is ignored.
//   clk, reset (async, active-low)
//   bus : text_write_ctrl_if.master (rx stream in, RAM port + status out)
// Revision    : 1.0 - initial release
// ============================================================================
module text_write_ctrl
  import txt_pkg::*;
#(
  parameter int         COLS  = TXT_COLS,
  parameter int         ROWS  = TXT_ROWS,
  parameter logic [7:0] BLANK = ASCII_BLANK
) (
  input  wire logic          clk,
  input  wire logic          reset,
  text_write_ctrl_if.master  bus
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int NW = CW + RW + 1;
  localparam logic [NW-1:0] C_ROW_END = NW'(COLS);
  localparam logic [NW-1:0] C_SCR_END = NW'(ROWS * COLS);

  txt_state_e    r_state, w_state_nxt;
  logic [NW-1:0] r_cnt, w_cnt_nxt;
  logic [RW-1:0] r_clr_row, w_clr_row_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_drop, w_drop_nxt;
  logic          r_we, w_we_nxt;
  logic [RW-1:0] r_ram_row, w_ram_row_nxt;
  logic [CW-1:0] r_ram_col, w_ram_col_nxt;
  logic [7:0]    r_wdata, w_wdata_nxt;

  cur_op_e       w_cur_op;
  logic [RW-1:0] w_cur_row, w_row_inc;
  logic [CW-1:0] w_cur_col;
  logic          w_wrap;

  text_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
    .clk      (clk),
    .reset    (reset),
    .op       (w_cur_op),
    .row      (w_cur_row),
    .col      (w_cur_col),
    .row_next (w_row_inc),
    .wrap     (w_wrap)
  );

  // r_cnt is the index of the next clear cell. A clear that starts from
  // IDLE issues its first write at the accepting edge, so r_cnt starts at 1;
  // a clear following a wrapping character starts at 0 because that edge
  // carries the character write.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_clr_row_nxt = r_clr_row;
    w_drop_nxt    = 1'b0;
    w_we_nxt      = 1'b0;
    w_ram_row_nxt = r_ram_row;
    w_ram_col_nxt = r_ram_col;
    w_wdata_nxt   = r_wdata;
    w_cur_op      = CUR_NOP;

    case (r_state)
      IDLE: begin
        if (bus.clr_req || (bus.rx_valid && bus.rx_data == ASCII_FF)) begin
          w_drop_nxt    = bus.clr_req && bus.rx_valid;
          w_cur_op      = CUR_HOME;
          w_state_nxt   = SCRCLR;
          w_we_nxt      = 1'b1;
          w_ram_row_nxt = '0;
          w_ram_col_nxt = '0;
          w_wdata_nxt   = BLANK;
          w_cnt_nxt     = NW'(1);
        end else if (bus.rx_valid) begin
          if (is_printable(bus.rx_data)) begin
            w_cur_op      = CUR_ADV;
            w_we_nxt      = 1'b1;
            w_ram_row_nxt = w_cur_row;
            w_ram_col_nxt = w_cur_col;
            w_wdata_nxt   = bus.rx_data;
            if (w_wrap) begin
              w_state_nxt   = ROWCLR;
              w_clr_row_nxt = w_row_inc;
              w_cnt_nxt     = '0;
            end
          end else if (bus.rx_data == ASCII_CR) begin
            w_cur_op = CUR_CR;
          end else if (bus.rx_data == ASCII_LF) begin
            w_cur_op      = CUR_NL;
            w_state_nxt   = ROWCLR;
            w_clr_row_nxt = w_row_inc;
            w_we_nxt      = 1'b1;
            w_ram_row_nxt = w_row_inc;
            w_ram_col_nxt = '0;
            w_wdata_nxt   = BLANK;
            w_cnt_nxt     = NW'(1);
          end
`ifdef TXT_BACKSPACE_EN
          else if (bus.rx_data == ASCII_BS && w_cur_col != '0) begin
            w_cur_op      = CUR_BACK;
            w_we_nxt      = 1'b1;
            w_ram_row_nxt = w_cur_row;
            w_ram_col_nxt = w_cur_col - 1'b1;
            w_wdata_nxt   = BLANK;
          end
`endif
        end
      end

      ROWCLR: begin
        w_drop_nxt = bus.rx_valid;
        if (bus.clr_req) begin
          // Abandon the row clear and restart as a full screen clear.
          w_cur_op      = CUR_HOME;
          w_state_nxt   = SCRCLR;
          w_we_nxt      = 1'b1;
          w_ram_row_nxt = '0;
          w_ram_col_nxt = '0;
          w_wdata_nxt   = BLANK;
          w_cnt_nxt     = NW'(1);
        end else if (r_cnt == C_ROW_END) begin
          w_state_nxt = IDLE;
        end else begin
          w_we_nxt      = 1'b1;
          w_ram_row_nxt = r_clr_row;
          w_ram_col_nxt = r_cnt[CW-1:0];
          w_wdata_nxt   = BLANK;
          w_cnt_nxt     = r_cnt + 1'b1;
        end
      end

      SCRCLR: begin
        w_drop_nxt = bus.rx_valid;
        if (r_cnt == C_SCR_END) begin
          w_state_nxt = IDLE;
        end else begin
          w_we_nxt      = 1'b1;
          w_ram_row_nxt = r_cnt[CW +: RW];
          w_ram_col_nxt = r_cnt[CW-1:0];
          w_wdata_nxt   = BLANK;
          w_cnt_nxt     = r_cnt + 1'b1;
        end
      end

      default: w_state_nxt = IDLE;
    endcase

    w_busy_nxt = (w_state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_clr_row <= '0;
      r_busy    <= 1'b0;
      r_drop    <= 1'b0;
      r_we      <= 1'b0;
      r_ram_row <= '0;
      r_ram_col <= '0;
      r_wdata   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_clr_row <= w_clr_row_nxt;
      r_busy    <= w_busy_nxt;
      r_drop    <= w_drop_nxt;
      r_we      <= w_we_nxt;
      r_ram_row <= w_ram_row_nxt;
      r_ram_col <= w_ram_col_nxt;
      r_wdata   <= w_wdata_nxt;
    end
  end

  assign bus.busy      = r_busy;
  assign bus.rx_drop   = r_drop;
  assign bus.ram_we    = r_we;
  assign bus.ram_row   = r_ram_row;
  assign bus.ram_col   = r_ram_col;
  assign bus.ram_wdata = r_wdata;
  assign bus.cur_row   = w_cur_row;
  assign bus.cur_col   = w_cur_col;

endmodule
`default_nettype wire

// File: tb/tb_text_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_text_write_ctrl
// Description : Self-checking bench for text_write_ctrl. A queue-based model
//               of pending RAM writes predicts every cycle; a vector table
//               and hand sequences cover the documented scenarios. Honours
//               TXT_BACKSPACE_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_text_write_ctrl;
  import txt_pkg::*;

  localparam int COLS   = 32;
  localparam int ROWS   = 4;
  localparam int K_CHAR = 0;
  localparam int K_ROW  = 1;
  localparam int K_SCR  = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  text_write_ctrl_if #(.COLS(COLS), .ROWS(ROWS)) bus ();

  text_write_ctrl #(.COLS(COLS), .ROWS(ROWS), .BLANK(8'h20)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: queue of pending writes ----------------
  typedef struct {int kind; int r; int c; int d;} wr_t;
  wr_t q[$];
  int m_row, m_col, m_we, m_wr, m_wc, m_wd, m_busy, m_drop, m_kind;

  task automatic model_reset();
    q.delete();
    m_row = 0; m_col = 0; m_we = 0; m_wr = 0; m_wc = 0; m_wd = 0;
    m_busy = 0; m_drop = 0; m_kind = K_CHAR;
  endtask

  task automatic push(input int kind, input int r, input int c, input int d);
    wr_t w;
    w.kind = kind; w.r = r; w.c = c; w.d = d;
    q.push_back(w);
  endtask

  task automatic push_row(input int r);
    for (int c = 0; c < COLS; c++) push(K_ROW, r, c, 32);
  endtask

  task automatic start_screen();
    q.delete();
    m_row = 0; m_col = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) push(K_SCR, r, c, 32);
  endtask

  task automatic model_edge(input int v, input int d, input int c);
    int kind;
    int drop;
    wr_t w;
    drop = 0;
    if (m_busy != 0) begin
      if (v != 0) drop = 1;
      if (c != 0) begin
        kind = (q.size() > 0) ? q[0].kind : m_kind;
        if (kind == K_ROW) start_screen();
      end
    end else if (c != 0) begin
      drop = v;
      start_screen();
    end else if (v != 0) begin
      if (d >= 32 && d <= 126) begin
        push(K_CHAR, m_row, m_col, d);
        if (m_col == COLS - 1) begin
          m_col = 0;
          m_row = (m_row + 1) % ROWS;
          push_row(m_row);
        end else begin
          m_col = m_col + 1;
        end
      end else if (d == 13) begin
        m_col = 0;
      end else if (d == 10) begin
        m_row = (m_row + 1) % ROWS;
        push_row(m_row);
      end else if (d == 12) begin
        start_screen();
      end
`ifdef TXT_BACKSPACE_EN
      else if (d == 8) begin
        if (m_col > 0) begin
          m_col = m_col - 1;
          push(K_CHAR, m_row, m_col, 32);
        end
      end
`endif
    end
    m_drop = drop;
    if (q.size() > 0) begin
      w = q.pop_front();
      m_we = 1; m_wr = w.r; m_wc = w.c; m_wd = w.d; m_kind = w.kind;
      m_busy = (w.kind != K_CHAR || q.size() > 0) ? 1 : 0;
    end else begin
      m_we = 0; m_busy = 0; m_kind = K_CHAR;
    end
  endtask

  // ---------------- observation counters for sequence checks ----------------
  int obs_wr, obs_blank, obs_busy, obs_drop;

  task automatic clear_obs();
    obs_wr = 0; obs_blank = 0; obs_busy = 0; obs_drop = 0;
  endtask

  task automatic check_outputs();
    chk("busy",    int'(bus.busy),    m_busy);
    chk("rx_drop", int'(bus.rx_drop), m_drop);
    chk("ram_we",  int'(bus.ram_we),  m_we);
    if (m_we != 0) begin
      chk("ram_row",   int'(bus.ram_row),   m_wr);
      chk("ram_col",   int'(bus.ram_col),   m_wc);
      chk("ram_wdata", int'(bus.ram_wdata), m_wd);
    end
    chk("cur_row", int'(bus.cur_row), m_row);
    chk("cur_col", int'(bus.cur_col), m_col);
    if (bus.ram_we) begin
      obs_wr++;
      if (bus.ram_wdata == 8'h20) obs_blank++;
    end
    if (bus.busy)    obs_busy++;
    if (bus.rx_drop) obs_drop++;
  endtask

  // Entered and left at a falling edge.
  task automatic step(input int v, input int d, input int c);
    bus.rx_valid = (v != 0);
    bus.rx_data  = 8'(d);
    bus.clr_req  = (c != 0);
    @(posedge clk);
    model_edge(v, d, c);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.clr_req  = 1'b0;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_busy"},    int'(bus.busy),      0);
    chk({tag, "_rx_drop"}, int'(bus.rx_drop),   0);
    chk({tag, "_ram_we"},  int'(bus.ram_we),    0);
    chk({tag, "_ram_row"}, int'(bus.ram_row),   0);
    chk({tag, "_ram_col"}, int'(bus.ram_col),   0);
    chk({tag, "_wdata"},   int'(bus.ram_wdata), 0);
    chk({tag, "_cur_row"}, int'(bus.cur_row),   0);
    chk({tag, "_cur_col"}, int'(bus.cur_col),   0);
  endtask

  typedef struct {
    int v; int d; int c;
    int e_we; int e_row; int e_col; int e_dat; int e_cr; int e_cc; int e_busy;
  } vec_t;
  vec_t tbl[11];

  initial begin
    int r, b, v, cl;

    // Table: {v, d, c, we, row, col, wdata, cur_row, cur_col, busy}
    tbl[0]  = '{1, 8'h41, 0, 1, 0, 0, 8'h41, 0, 1, 0};
    tbl[1]  = '{1, 8'h42, 0, 1, 0, 1, 8'h42, 0, 2, 0};
    tbl[2]  = '{1, 8'h0D, 0, 0, 0, 0, 0,     0, 0, 0};
    tbl[3]  = '{1, 8'h07, 0, 0, 0, 0, 0,     0, 0, 0};
    tbl[4]  = '{1, 8'h7F, 0, 0, 0, 0, 0,     0, 0, 0};
    tbl[5]  = '{1, 8'h7A, 0, 1, 0, 0, 8'h7A, 0, 1, 0};
    tbl[6]  = '{1, 8'h7E, 0, 1, 0, 1, 8'h7E, 0, 2, 0};
    tbl[7]  = '{1, 8'h1F, 0, 0, 0, 0, 0,     0, 2, 0};
    tbl[8]  = '{0, 8'h41, 0, 0, 0, 0, 0,     0, 2, 0};
`ifdef TXT_BACKSPACE_EN
    tbl[9]  = '{1, 8'h08, 0, 1, 0, 1, 8'h20, 0, 1, 0};
`else
    tbl[9]  = '{1, 8'h08, 0, 0, 0, 0, 0,     0, 2, 0};
`endif
    tbl[10] = '{1, 8'h0C, 0, 1, 0, 0, 8'h20, 0, 0, 1};

    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.clr_req  = 1'b0;
    model_reset();
    clear_obs();

    repeat (3) @(negedge clk);
    chk_reset_values("reset");
    reset = 1'b1;
    idle(9);

    // ---- table vectors ----
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].c);
      chk($sformatf("vec%0d_we", i),   int'(bus.ram_we), tbl[i].e_we);
      chk($sformatf("vec%0d_busy", i), int'(bus.busy),   tbl[i].e_busy);
      if (tbl[i].e_we != 0) begin
        chk($sformatf("vec%0d_row", i),   int'(bus.ram_row),   tbl[i].e_row);
        chk($sformatf("vec%0d_col", i),   int'(bus.ram_col),   tbl[i].e_col);
        chk($sformatf("vec%0d_wdata", i), int'(bus.ram_wdata), tbl[i].e_dat);
      end
      chk($sformatf("vec%0d_cur_row", i), int'(bus.cur_row), tbl[i].e_cr);
      chk($sformatf("vec%0d_cur_col", i), int'(bus.cur_col), tbl[i].e_cc);
    end
    idle(130);

    // ---- screen clear with a byte injected mid-clear ----
    clear_obs();
    step(0, 0, 1);
    idle(50);
    step(1, 8'h51, 0);
    idle(90);
    chk("scr_writes", obs_wr, 128);
    chk("scr_blanks", obs_blank, 128);
    chk("scr_busy_cycles", obs_busy, 128);
    chk("scr_drop_pulses", obs_drop, 1);

    // ---- 32 printables from (0,0): wrap and row-1 clear ----
    clear_obs();
    for (int i = 0; i < COLS; i++) step(1, 8'h41 + (i % 26), 0);
    idle(40);
    chk("wrap_writes", obs_wr, 64);
    chk("wrap_blanks", obs_blank, 32);
    chk("wrap_busy_cycles", obs_busy, 33);
    chk("wrap_cur_row", int'(bus.cur_row), 1);
    chk("wrap_cur_col", int'(bus.cur_col), 0);

    // ---- "X", CR, LF from (2,5) ----
    step(1, 8'h0A, 0);
    idle(40);
    for (int i = 0; i < 5; i++) step(1, 8'h61, 0);
    step(1, 8'h58, 0);
    chk("x_row", int'(bus.ram_row), 2);
    chk("x_col", int'(bus.ram_col), 5);
    chk("x_data", int'(bus.ram_wdata), 8'h58);
    step(1, 8'h0D, 0);
    chk("cr_col", int'(bus.cur_col), 0);
    clear_obs();
    step(1, 8'h0A, 0);
    idle(40);
    chk("lf_blanks", obs_blank, 32);
    chk("lf_busy_cycles", obs_busy, 32);
    chk("lf_cur_row", int'(bus.cur_row), 3);
    step(1, 8'h0A, 0);
    idle(40);
    chk("lf_wrap_cur_row", int'(bus.cur_row), 0);
    chk("lf_wrap_cur_col", int'(bus.cur_col), 0);

    // ---- clr_req and rx_valid in the same cycle ----
    step(1, 8'h5A, 1);
    chk("clr_rx_drop", int'(bus.rx_drop), 1);
    chk("clr_rx_busy", int'(bus.busy), 1);
    idle(130);

    // ---- clr_req aborting a row clear ----
    step(1, 8'h0A, 0);
    idle(5);
    clear_obs();
    step(0, 0, 1);
    chk("abort_row", int'(bus.ram_row), 0);
    chk("abort_col", int'(bus.ram_col), 0);
    idle(130);
    chk("abort_writes", obs_wr, 128);
    chk("abort_cur_row", int'(bus.cur_row), 0);

    // ---- backspace ----
    step(1, 8'h0A, 0);
    idle(40);
    step(1, 8'h08, 0);
    chk("bs_col0_we", int'(bus.ram_we), 0);
    chk("bs_col0_cur_col", int'(bus.cur_col), 0);
    for (int i = 0; i < 4; i++) step(1, 8'h62, 0);
    step(1, 8'h08, 0);
`ifdef TXT_BACKSPACE_EN
    chk("bs_we", int'(bus.ram_we), 1);
    chk("bs_row", int'(bus.ram_row), 1);
    chk("bs_col", int'(bus.ram_col), 3);
    chk("bs_data", int'(bus.ram_wdata), 8'h20);
    chk("bs_cur_col", int'(bus.cur_col), 3);
`else
    chk("bs_we", int'(bus.ram_we), 0);
    chk("bs_cur_col", int'(bus.cur_col), 4);
`endif

    // ---- randomized traffic against the model ----
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      b = $urandom_range(32, 126);
      else if (r < 75) b = 13;
      else if (r < 78) b = 10;
      else if (r < 79) b = 12;
      else if (r < 85) b = 8;
      else             b = $urandom_range(0, 255);
      v  = ($urandom_range(0, 2) != 0) ? 1 : 0;
      cl = ($urandom_range(0, 199) == 0) ? 1 : 0;
      step(v, b, cl);
    end
    idle(140);

    // ---- reset in the middle of a screen clear ----
    step(0, 0, 1);
    idle(20);
    reset = 1'b0;
    #1;
    chk_reset_values("midclr");
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    idle(5);
    step(1, 8'h43, 0);
    chk("post_reset_col", int'(bus.ram_col), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
